// File: rtl/fft_out_reorder_if.sv
// Bundles the 4-lane FFT input and the natural-order output stream of fft_out_reorder.
// An output beat transfers on a rising clk edge where out_valid && out_ready; while out_valid is
// high and out_ready low, out_data/out_index/out_last hold. out_valid never drops without a transfer.
interface fft_out_reorder_if #(
    parameter int NBITS_out = 15,
    parameter int LOG2N     = 7
) ();
    logic                   in_valid;
    logic                   in_sof;
    logic [2*NBITS_out-1:0] fftIn0_up;
    logic [2*NBITS_out-1:0] fftIn0_down;
    logic [2*NBITS_out-1:0] fftIn1_up;
    logic [2*NBITS_out-1:0] fftIn1_down;
    logic [2*NBITS_out-1:0] out_data;
    logic [LOG2N-1:0]       out_index;
    logic                   out_valid;
    logic                   out_last;
    logic                   out_ready;
    logic                   ovf;
    logic                   frame_err;
    logic [7:0]             drop_cnt;
    // {buf1 state, buf0 state, writer state, reader state}
    logic [6:0]             dbg_state;

    modport slave (
        input  in_valid, in_sof, fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, out_ready,
        output out_data, out_index, out_valid, out_last, ovf, frame_err, drop_cnt, dbg_state
    );

    modport master (
        output in_valid, in_sof, fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, out_ready,
        input  out_data, out_index, out_valid, out_last, ovf, frame_err, drop_cnt, dbg_state
    );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong frame buffer that turns the FFT core's bit-reversed 4-lane output into a
// natural-order, one-bin-per-clock stream; frames arriving with no free buffer are dropped.
module fft_out_reorder #(
    parameter int NBITS_out = 15,
    parameter int N         = 128,
    parameter int LOG2N     = 7
) (
    input logic            clk,
    input logic            rst,
    fft_out_reorder_if.slave bus
);
    localparam int DW    = 2 * NBITS_out;
    localparam int WW    = LOG2N - 2;
    localparam int DEPTH = N / 4;
    localparam logic [WW-1:0]    K_LAST   = WW'(DEPTH - 1);
    localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);

    typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_FULL, BUF_READING} buf_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_FILL, WR_DROP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

    function automatic logic [WW-1:0] bitrev_w(input logic [WW-1:0] v);
        logic [WW-1:0] r;
        for (int i = 0; i < WW; i++) r[i] = v[WW-1-i];
        return r;
    endfunction

    buf_state_t       buf_state [2];
    buf_state_t       buf_next  [2];
    wr_state_t        wr_state, wr_next;
    rd_state_t        rd_state, rd_next;
    logic             wr_ptr, rd_ptr;
    logic [WW-1:0]    wr_k, k_next, wr_addr_k, wr_addr;
    logic             wr_en, set_fill, set_full, ovf_next, ferr_next, drop_evt;
    logic             rd_load, set_reading, set_empty;
    logic [LOG2N-1:0] rd_addr;
    logic [DW-1:0]    rd_word;
    logic [DW-1:0]    mem [8][DEPTH];

    logic             valid_q, last_q, ovf_q, ferr_q;
    logic [LOG2N-1:0] index_q;
    logic [DW-1:0]    data_q;
    logic [7:0]       drop_q;

    // Writer: accepts a frame only into the buffer next in arrival order.
    always_comb begin
        wr_next   = wr_state;
        k_next    = wr_k;
        wr_en     = 1'b0;
        wr_addr_k = '0;
        set_fill  = 1'b0;
        set_full  = 1'b0;
        ovf_next  = 1'b0;
        ferr_next = 1'b0;
        drop_evt  = 1'b0;
        unique case (wr_state)
            WR_IDLE, WR_DROP: begin
                if (bus.in_valid && bus.in_sof) begin
                    if (buf_state[wr_ptr] == BUF_EMPTY) begin
                        wr_en    = 1'b1;
                        set_fill = 1'b1;
                        k_next   = WW'(1);
                        wr_next  = WR_FILL;
                    end else begin
                        ovf_next = 1'b1;
                        drop_evt = 1'b1;
                        wr_next  = WR_DROP;
                    end
                end
            end
            WR_FILL: begin
                if (bus.in_valid) begin
                    wr_en = 1'b1;
                    if (bus.in_sof) begin
                        ferr_next = 1'b1;
                        k_next    = WW'(1);
                    end else begin
                        wr_addr_k = wr_k;
                        if (wr_k == K_LAST) begin
                            set_full = 1'b1;
                            k_next   = '0;
                            wr_next  = WR_IDLE;
                        end else begin
                            k_next = wr_k + 1'b1;
                        end
                    end
                end
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next     = rd_state;
        rd_load     = 1'b0;
        rd_addr     = '0;
        set_reading = 1'b0;
        set_empty   = 1'b0;
        unique case (rd_state)
            RD_IDLE: begin
                if (buf_state[rd_ptr] == BUF_FULL) begin
                    set_reading = 1'b1;
                    rd_load     = 1'b1;
                    rd_next     = RD_SEND;
                end
            end
            RD_SEND: begin
                if (valid_q && bus.out_ready) begin
                    if (index_q == IDX_LAST) begin
                        set_empty = 1'b1;
                        rd_next   = RD_IDLE;
                    end else begin
                        rd_load = 1'b1;
                        rd_addr = index_q + 1'b1;
                    end
                end
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // Writer and reader never touch a buffer in the same state, so their updates cannot collide.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            buf_next[b] = buf_state[b];
            if (set_fill    && wr_ptr == 1'(b)) buf_next[b] = BUF_FILLING;
            if (set_full    && wr_ptr == 1'(b)) buf_next[b] = BUF_FULL;
            if (set_reading && rd_ptr == 1'(b)) buf_next[b] = BUF_READING;
            if (set_empty   && rd_ptr == 1'(b)) buf_next[b] = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_state[0] <= BUF_EMPTY;
            buf_state[1] <= BUF_EMPTY;
            wr_state     <= WR_IDLE;
            rd_state     <= RD_IDLE;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            wr_k         <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            index_q      <= '0;
            data_q       <= '0;
            ovf_q        <= 1'b0;
            ferr_q       <= 1'b0;
            drop_q       <= '0;
        end else begin
            buf_state[0] <= buf_next[0];
            buf_state[1] <= buf_next[1];
            wr_state     <= wr_next;
            rd_state     <= rd_next;
            wr_ptr       <= wr_ptr ^ set_full;
            rd_ptr       <= rd_ptr ^ set_empty;
            wr_k         <= k_next;
            valid_q      <= (rd_next == RD_SEND);
            if (rd_load) begin
                data_q  <= rd_word;
                index_q <= rd_addr;
                last_q  <= (rd_addr == IDX_LAST);
            end else if (set_empty) begin
                index_q <= '0;
                last_q  <= 1'b0;
            end
            ovf_q  <= ovf_next;
            ferr_q <= ferr_next;
            if (drop_evt && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    // Lane L always holds bins whose top two bits are bitrev2(L): lanes 0..3 map to banks 0,2,1,3.
    assign wr_addr = bitrev_w(wr_addr_k);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_ptr, 2'd0}][wr_addr] <= bus.fftIn0_up;
            mem[{wr_ptr, 2'd2}][wr_addr] <= bus.fftIn0_down;
            mem[{wr_ptr, 2'd1}][wr_addr] <= bus.fftIn1_up;
            mem[{wr_ptr, 2'd3}][wr_addr] <= bus.fftIn1_down;
        end
    end

    assign rd_word = mem[{rd_ptr, rd_addr[LOG2N-1 -: 2]}][rd_addr[WW-1:0]];

    assign bus.out_data  = data_q;
    assign bus.out_index = index_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.ovf       = ovf_q;
    assign bus.frame_err = ferr_q;
    assign bus.drop_cnt  = drop_q;
    assign bus.dbg_state = {buf_state[1], buf_state[0], wr_state, rd_state};
endmodule
